// File: rtl/tictactoe_pkg.sv
// Shared screen-state encoding and result types for the tic-tac-toe display path.
package tictactoe_pkg;

    localparam int HOLD_FRAMES_DEFAULT = 180;

    // One-hot so each bit of the state register drives its screen enable directly.
    typedef enum logic [4:0] {
        SCR_SS  = 5'b00001,
        SCR_PS  = 5'b00010,
        SCR_WSX = 5'b00100,
        SCR_WSO = 5'b01000,
        SCR_T   = 5'b10000
    } screen_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_X    = 2'd1,
        RES_O    = 2'd2,
        RES_TIE  = 2'd3
    } result_e;

    function automatic result_e pick_result(input logic x, input logic o, input logic t);
        if (x)      return RES_X;
        else if (o) return RES_O;
        else if (t) return RES_TIE;
        else        return RES_NONE;
    endfunction

    function automatic screen_e result_screen(input result_e r);
        case (r)
            RES_X:   return SCR_WSX;
            RES_O:   return SCR_WSO;
            RES_TIE: return SCR_T;
            default: return SCR_SS;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchronizer for an asynchronous button plus a one-cycle rising-edge pulse.
module btn_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/game_screen_sequencer.sv
// Frame-aligned screen sequencer: start -> play -> result -> start.
// Optional SCREEN_AUTORETURN_EN: result screens return to start after HOLD_FRAMES frames.
module game_screen_sequencer
    import tictactoe_pkg::*;
#(
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic start_btn,
    input  logic win_x,
    input  logic win_o,
    input  logic tie,
    input  logic vsync,
    output logic ceSS,
    output logic cePS,
    output logic ceWSX,
    output logic ceWSO,
    output logic ceT,
    output logic new_game
);

    screen_e state;
    result_e res_req;
    logic    start_req;
    logic    start_rise;
    logic    vsync_q;
    logic    frame_tick;
    logic    is_result;
    logic    hold_done;
    logic    advance;

    btn_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_start_sync (
        .clk  (clk_100MHz),
        .rst  (reset),
        .din  (start_btn),
        .rise (start_rise)
    );

    // History resets low so a vsync already low at reset release cannot fake a frame start.
    assign frame_tick = vsync_q & ~vsync;
    assign is_result  = state inside {SCR_WSX, SCR_WSO, SCR_T};

`ifdef SCREEN_AUTORETURN_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    logic [7:0] frame_cnt;

    assign hold_done = (frame_cnt == HOLD_LAST);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (frame_tick && advance) begin
            frame_cnt <= 8'd0;
        end else if (frame_tick && is_result && frame_cnt != 8'hFF) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign hold_done = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        advance = 1'b0;
        case (state)
            SCR_SS:                  advance = start_req;
            SCR_PS:                  advance = (res_req != RES_NONE);
            SCR_WSX, SCR_WSO, SCR_T: advance = start_req | hold_done;
            default:                 advance = 1'b1;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= SCR_SS;
            new_game  <= 1'b0;
            start_req <= 1'b0;
            res_req   <= RES_NONE;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            new_game <= 1'b0;

            // Latch first; a consuming transition below overrides, keeping same-edge events.
            if (state == SCR_PS) begin
                start_req <= 1'b0;
                if (res_req == RES_NONE) res_req <= pick_result(win_x, win_o, tie);
            end else if (start_rise) begin
                start_req <= 1'b1;
            end

            if (frame_tick && advance) begin
                case (state)
                    SCR_SS: begin
                        state     <= SCR_PS;
                        new_game  <= 1'b1;
                        start_req <= start_rise;
                    end
                    SCR_PS: begin
                        state   <= result_screen(res_req);
                        res_req <= RES_NONE;
                    end
                    SCR_WSX, SCR_WSO, SCR_T: begin
                        state     <= SCR_SS;
                        start_req <= start_rise;
                    end
                    default: begin
                        state <= SCR_SS;
                    end
                endcase
            end
        end
    end

    assign {ceT, ceWSO, ceWSX, cePS, ceSS} = state;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Self-checking bench for game_screen_sequencer; honours SCREEN_AUTORETURN_EN when defined.
`timescale 1ns/1ps
module tb_game_screen_sequencer;

    localparam int FRAME_HI = 6;
`ifdef SCREEN_AUTORETURN_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 180;
`endif

    localparam logic [4:0] E_SS  = 5'b00001;
    localparam logic [4:0] E_PS  = 5'b00010;
    localparam logic [4:0] E_WSX = 5'b00100;
    localparam logic [4:0] E_WSO = 5'b01000;
    localparam logic [4:0] E_T   = 5'b10000;

    logic clk_100MHz = 1'b0;
    logic reset, start_btn, win_x, win_o, tie, vsync;
    logic ceSS, cePS, ceWSX, ceWSO, ceT, new_game;
    logic [4:0] ce;

    assign ce = {ceT, ceWSO, ceWSX, cePS, ceSS};

    always #5 clk_100MHz = ~clk_100MHz;

    game_screen_sequencer #(
        .HOLD_FRAMES (HOLD),
        .SYNC_STAGES (2)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .start_btn  (start_btn),
        .win_x      (win_x),
        .win_o      (win_o),
        .tie        (tie),
        .vsync      (vsync),
        .ceSS       (ceSS),
        .cePS       (cePS),
        .ceWSX      (ceWSX),
        .ceWSO      (ceWSO),
        .ceT        (ceT),
        .new_game   (new_game)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0] ce;
        logic       ng;
    } exp_t;

    typedef struct {
        logic       press;
        logic       wx;
        logic       wo;
        logic       t;
        logic [4:0] exp_ce;
        logic       exp_ng;
    } step_t;

    exp_t       sb[$];
    logic [4:0] prev_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exactly one screen enable every cycle, including during reset.
    always @(negedge clk_100MHz) check("onehot", 32'($countones(ce)), 32'd1);

    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic press();
        start_btn = 1'b1;
        repeat (4) cyc();
        start_btn = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic pulse_result(input logic x, input logic o, input logic t);
        win_x = x;
        win_o = o;
        tie   = t;
        cyc();
        win_x = 1'b0;
        win_o = 1'b0;
        tie   = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic expect_tick(input logic [4:0] e_ce, input logic e_ng);
        exp_t e;
        e.ce = e_ce;
        e.ng = e_ng;
        sb.push_back(e);
    endtask

    // Drives one vsync falling edge and compares the frame-boundary result from the scoreboard.
    task automatic tick_and_check(input string name);
        exp_t e;
        vsync = 1'b0;
        cyc();
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, "_ce"}, 32'(ce), 32'(e.ce));
            check({name, "_new_game"}, 32'(new_game), 32'(e.ng));
            cyc();
            if (e.ng) check({name, "_new_game_width"}, 32'(new_game), 32'd0);
            prev_exp = e.ce;
        end
        vsync = 1'b1;
        repeat (FRAME_HI) cyc();
    endtask

    localparam int NSTEPS = 19;
    step_t steps[NSTEPS];

    initial begin
        steps[0]  = '{0, 1, 1, 0, E_WSX, 0};
        steps[1]  = '{0, 0, 0, 1, E_WSX, 0};
        steps[2]  = '{1, 0, 0, 0, E_SS,  0};
        steps[3]  = '{0, 1, 0, 0, E_SS,  0};
        steps[4]  = '{0, 0, 0, 0, E_SS,  0};
        steps[5]  = '{1, 0, 0, 0, E_PS,  1};
        steps[6]  = '{0, 0, 1, 1, E_WSO, 0};
        steps[7]  = '{0, 0, 0, 0, E_WSO, 0};
        steps[8]  = '{1, 0, 0, 0, E_SS,  0};
        steps[9]  = '{1, 0, 0, 0, E_PS,  1};
        steps[10] = '{1, 0, 0, 0, E_PS,  0};
        steps[11] = '{0, 0, 0, 1, E_T,   0};
        steps[12] = '{0, 0, 0, 0, E_T,   0};
        steps[13] = '{1, 0, 0, 0, E_SS,  0};
        steps[14] = '{1, 0, 0, 0, E_PS,  1};
        steps[15] = '{1, 1, 0, 0, E_WSX, 0};
        steps[16] = '{0, 0, 0, 0, E_WSX, 0};
        steps[17] = '{1, 0, 0, 0, E_SS,  0};
        steps[18] = '{1, 0, 0, 0, E_PS,  1};

        reset     = 1'b1;
        start_btn = 1'b0;
        win_x     = 1'b0;
        win_o     = 1'b0;
        tie       = 1'b0;
        vsync     = 1'b1;
        prev_exp  = E_SS;
        repeat (3) cyc();
        check("reset_ce", 32'(ce), 32'(E_SS));
        check("reset_new_game", 32'(new_game), 32'd0);
        reset = 1'b0;
        repeat (3) cyc();
        check("post_reset_ce", 32'(ce), 32'(E_SS));

        // Start pressed mid-frame: no switch until the next vsync falling edge.
        press();
        check("start_mid_frame_hold", 32'(ce), 32'(E_SS));
        repeat (3) cyc();
        check("start_mid_frame_hold2", 32'(ce), 32'(E_SS));
        expect_tick(E_PS, 1'b1);
        tick_and_check("start_to_play");

        for (int i = 0; i < NSTEPS; i++) begin
            if (steps[i].press) press();
            if (steps[i].wx || steps[i].wo || steps[i].t)
                pulse_result(steps[i].wx, steps[i].wo, steps[i].t);
            check($sformatf("step%0d_hold", i), 32'(ce), 32'(prev_exp));
            expect_tick(steps[i].exp_ce, steps[i].exp_ng);
            tick_and_check($sformatf("step%0d", i));
        end

        // Tie coincident with the frame tick is deferred to the following frame.
        vsync = 1'b0;
        tie   = 1'b1;
        cyc();
        tie = 1'b0;
        check("tie_on_tick_stays_ps", 32'(ce), 32'(E_PS));
        cyc();
        vsync = 1'b1;
        repeat (FRAME_HI) cyc();
        check("tie_on_tick_hold", 32'(ce), 32'(E_PS));
        expect_tick(E_T, 1'b0);
        tick_and_check("tie_deferred");

        press();
        expect_tick(E_SS, 1'b0);
        tick_and_check("tie_to_start");
        press();
        expect_tick(E_PS, 1'b1);
        tick_and_check("to_play_again");
        pulse_result(1'b0, 1'b1, 1'b0);
        expect_tick(E_WSO, 1'b0);
        tick_and_check("o_wins");

`ifdef SCREEN_AUTORETURN_EN
        for (int f = 1; f <= HOLD; f++) begin
            expect_tick((f == HOLD) ? E_SS : E_WSO, 1'b0);
            tick_and_check($sformatf("autoreturn_f%0d", f));
        end
`else
        for (int f = 1; f <= 300; f++) begin
            expect_tick(E_WSO, 1'b0);
            tick_and_check($sformatf("wso_held_f%0d", f));
        end
        press();
        expect_tick(E_SS, 1'b0);
        tick_and_check("wso_to_start");
`endif

        press();
        expect_tick(E_PS, 1'b1);
        tick_and_check("play_before_reset");
        pulse_result(1'b1, 1'b0, 1'b0);
        expect_tick(E_WSX, 1'b0);
        tick_and_check("x_wins_before_reset");

        // Pending start in WSX, then an asynchronous reset between clock edges.
        press();
        check("wsx_pending_hold", 32'(ce), 32'(E_WSX));
        @(posedge clk_100MHz);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_ce", 32'(ce), 32'(E_SS));
        check("async_reset_new_game", 32'(new_game), 32'd0);
        repeat (2) cyc();
        reset = 1'b0;
        repeat (3) cyc();
        expect_tick(E_SS, 1'b0);
        tick_and_check("stale_start_dropped");
        press();
        expect_tick(E_PS, 1'b1);
        tick_and_check("play_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
